// File: rtl/data_unbuffer.sv
// Frame transmitter: serializes a CYCLES-word block as a one-cycle data_start
// strobe followed by CYCLES words, lowest word first, with a one-deep queue.
module data_unbuffer #(
  parameter int WORD_W = 16,
  parameter int CYCLES = 8
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       load,
  input  logic [WORD_W*CYCLES-1:0]   frame_in,
  output logic                       ready,
  output logic                       data_start,
  output logic [WORD_W-1:0]          data,
  output logic                       busy,
  output logic                       frame_done
);

  localparam int FW = WORD_W * CYCLES;
  localparam int CW = $clog2(CYCLES);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  typedef enum logic [1:0] {IDLE, START, SEND} state_t;

  // Handshake: a frame is taken on any rising edge where load && ready; ready
  // depends only on the pending flag, so load never combinationally affects it.
  state_t          state;
  logic [FW-1:0]   shift;
  logic [FW-1:0]   pend;
  logic            pend_v;
  logic [CW-1:0]   cnt;
  logic            accept;
  logic            last_word;

  assign accept    = load && !pend_v;
  assign last_word = (state == SEND) && (cnt == LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      shift  <= '0;
      pend   <= '0;
      pend_v <= 1'b0;
      cnt    <= '0;
      data   <= '0;
    end else begin
      case (state)
        IDLE: begin
          // An accepted load bypasses pend and starts immediately.
          if (pend_v) begin
            shift  <= pend;
            pend_v <= 1'b0;
            state  <= START;
          end else if (load) begin
            shift <= frame_in;
            state <= START;
          end
        end
        START: begin
          cnt   <= '0;
          data  <= shift[WORD_W-1:0];
          shift <= shift >> WORD_W;
          state <= SEND;
          if (accept) begin
            pend   <= frame_in;
            pend_v <= 1'b1;
          end
        end
        SEND: begin
          if (cnt != LAST) begin
            cnt   <= cnt + CW'(1);
            data  <= shift[WORD_W-1:0];
            shift <= shift >> WORD_W;
            if (accept) begin
              pend   <= frame_in;
              pend_v <= 1'b1;
            end
          end else if (pend_v) begin
            // Queued frame follows the last word with no idle cycle.
            shift  <= pend;
            pend_v <= 1'b0;
            state  <= START;
          end else if (load) begin
            shift <= frame_in;
            state <= START;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ready      = !pend_v;
  assign data_start = (state == START);
  assign busy       = (state != IDLE);
  assign frame_done = last_word;

endmodule

// File: tb/tb_data_unbuffer.sv
// Bench for data_unbuffer: per-cycle comparison against a frame-schedule model
// plus a capture-buffer loopback that reassembles each frame.
module tb_data_unbuffer;

  localparam int WORD_W = 16;
  localparam int CYCLES = 8;
  localparam int FW     = WORD_W * CYCLES;

  typedef struct {
    int            start;
    logic [FW-1:0] frame;
  } sched_t;

  logic                clock;
  logic                reset_n;
  logic                load;
  logic [FW-1:0]       frame_in;
  logic                ready;
  logic                data_start;
  logic [WORD_W-1:0]   data;
  logic                busy;
  logic                frame_done;

  int n_vec;
  int n_err;

  // Model: each accepted frame owns cycles start..start+CYCLES.
  sched_t            sched_q[$];
  logic [FW-1:0]     exp_q[$];
  int                cyc;
  int                last_start;
  int                end_c;
  logic [WORD_W-1:0] last_data;
  int                n_acc;
  int                n_cap;

  logic              cap_active;
  int                cap_idx;
  logic [FW-1:0]     cap_buf;

  data_unbuffer #(.WORD_W(WORD_W), .CYCLES(CYCLES)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (load),
    .frame_in   (frame_in),
    .ready      (ready),
    .data_start (data_start),
    .data       (data),
    .busy       (busy),
    .frame_done (frame_done)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    sched_q.delete();
    exp_q.delete();
    cyc        = 0;
    last_start = -100;
    end_c      = -100;
    last_data  = '0;
    cap_active = 1'b0;
    cap_idx    = 0;
  endtask

  // Applied right after each rising edge using the inputs that were set up for it.
  task automatic model_edge(input logic accepted_sampled_load, input logic [FW-1:0] f);
    int st;
    cyc++;
    if (accepted_sampled_load && reset_n && last_start <= cyc - 1) begin
      st = (end_c + 1 > cyc) ? end_c + 1 : cyc;
      sched_q.push_back('{start: st, frame: f});
      exp_q.push_back(f);
      last_start = st;
      end_c      = st + CYCLES;
      n_acc++;
    end
    while (sched_q.size() > 0 && sched_q[0].start + CYCLES < cyc) void'(sched_q.pop_front());
  endtask

  task automatic compare_outputs();
    logic              e_start, e_done, e_busy, e_ready;
    logic [WORD_W-1:0] e_data;
    logic [FW-1:0]     fr;
    int                off;
    e_start = 1'b0;
    e_done  = 1'b0;
    e_busy  = 1'b0;
    e_data  = last_data;
    if (sched_q.size() > 0 && sched_q[0].start <= cyc) begin
      fr     = sched_q[0].frame;
      off    = cyc - sched_q[0].start;
      e_busy = 1'b1;
      if (off == 0) e_start = 1'b1;
      else e_data = fr[(off-1)*WORD_W +: WORD_W];
      e_done = (off == CYCLES);
    end
    last_data = e_data;
    e_ready   = (last_start <= cyc);
    check("ready",      FW'(ready),      FW'(e_ready));
    check("data_start", FW'(data_start), FW'(e_start));
    check("data",       FW'(data),       FW'(e_data));
    check("busy",       FW'(busy),       FW'(e_busy));
    check("frame_done", FW'(frame_done), FW'(e_done));
    // Capture buffer: sample data_start, then one word per clock.
    if (cap_active) begin
      cap_buf[cap_idx*WORD_W +: WORD_W] = data;
      cap_idx++;
      if (cap_idx == CYCLES) begin
        cap_active = 1'b0;
        n_cap++;
        if (exp_q.size() == 0) check("capture_underflow", FW'(1), FW'(0));
        else check("loopback", cap_buf, exp_q.pop_front());
      end
    end
    if (data_start) begin
      cap_active = 1'b1;
      cap_idx    = 0;
    end
  endtask

  // Driver: present inputs at the falling edge, model the rising edge, then compare.
  task automatic step(input logic ld, input logic [FW-1:0] f);
    load     = ld;
    frame_in = f;
    @(posedge clock);
    model_edge(ld, f);
    @(negedge clock);
    compare_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, rand_frame());
  endtask

  function automatic logic [FW-1:0] rand_frame();
    logic [FW-1:0] f;
    for (int i = 0; i < FW / 32; i++) f[i*32 +: 32] = $urandom;
    return f;
  endfunction

  initial begin
    logic [FW-1:0] ramp;
    logic [FW-1:0] fa, fb, fc;
    int            steps;
    int            start_acc;
    n_vec = 0;
    n_err = 0;
    n_acc = 0;
    n_cap = 0;
    reset_n  = 1'b0;
    load     = 1'b0;
    frame_in = '0;
    model_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    compare_outputs();
    reset_n = 1'b1;

    // Single frame with word i = i
    for (int i = 0; i < CYCLES; i++) ramp[i*WORD_W +: WORD_W] = WORD_W'(i);
    step(1'b1, ramp);
    idle(11);

    // Back-to-back plus a refused third load
    fa = rand_frame(); fb = rand_frame(); fc = rand_frame();
    step(1'b1, fa);
    idle(3);
    step(1'b1, fb);
    step(1'b0, '0);
    step(1'b1, fc);
    idle(20);

    // Load on the final SEND edge of A with nothing pending
    fa = rand_frame(); fb = rand_frame();
    step(1'b1, fa);
    idle(CYCLES);
    step(1'b1, fb);
    idle(12);

    // Asynchronous reset mid-frame
    fa = rand_frame(); fb = rand_frame();
    step(1'b1, fa);
    idle(2);
    step(1'b1, fb);
    idle(1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_ready",      FW'(ready),      FW'(1));
    check("rst_data_start", FW'(data_start), FW'(0));
    check("rst_data",       FW'(data),       FW'(0));
    check("rst_busy",       FW'(busy),       FW'(0));
    check("rst_frame_done", FW'(frame_done), FW'(0));
    model_reset();
    @(negedge clock);
    idle(2);
    reset_n = 1'b1;
    idle(4);

    // Random loads: at least 100 accepted frames through the loopback
    start_acc = n_acc;
    steps     = 0;
    while (n_acc - start_acc < 100 && steps < 5000) begin
      step(($urandom_range(0, 3) == 0), rand_frame());
      steps++;
    end
    check("random_frames_accepted", FW'(n_acc - start_acc >= 100), FW'(1));
    idle(2 * (CYCLES + 1) + 2);
    check("exp_q_drained", FW'(exp_q.size()), FW'(0));
    check("capture_active_end", FW'(cap_active), FW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
